// File: rtl/rect_drop_ctl.sv
// Per-frame rectangle motion controller: follows the mouse, drops on a left press, settles on FLOOR_Y.
// Define RECT_DROP_BOUNCE_EN to enable bouncing (RISE state); otherwise the first floor contact ends motion.
module rect_drop_ctl #(
    parameter int unsigned FLOOR_Y    = 536,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned VMAX       = 64,
    parameter int unsigned MIN_BOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        mouse_left,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    output logic [11:0] rect_xpos,
    output logic [11:0] rect_ypos,
    output logic        moving
);

    localparam logic [11:0] FLOOR = 12'(FLOOR_Y);
    localparam logic [11:0] GRAV  = 12'(GRAVITY);
    localparam logic [11:0] VLIM  = 12'(VMAX);

`ifdef RECT_DROP_BOUNCE_EN
    localparam logic [11:0] MINB  = 12'(MIN_BOUNCE);
    typedef enum logic [1:0] {FOLLOW, FALL, RISE, REST} state_t;
`else
    typedef enum logic [1:0] {FOLLOW, FALL, REST} state_t;
`endif

    state_t      state;
    logic [11:0] vel;
    logic        btn_q;
    logic        armed;
    logic        drop_req;
    logic        press;
    logic        req;
    logic [12:0] fall_sum;
    logic [12:0] vel_inc;
    logic [11:0] mouse_y_cl;

    // armed masks the first cycle after reset so a held button is not seen as a press
    assign press      = mouse_left & ~btn_q & armed;
    assign req        = drop_req | press;
    assign fall_sum   = {1'b0, rect_ypos} + {1'b0, vel};
    assign vel_inc    = {1'b0, vel} + {1'b0, GRAV};
    assign mouse_y_cl = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;

`ifdef RECT_DROP_BOUNCE_EN
    logic [11:0] bounce_v;
    logic [12:0] rise_diff;
    assign bounce_v  = vel - (vel >> 2);
    assign rise_diff = {1'b0, rect_ypos} - {1'b0, vel};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q    <= 1'b0;
            armed    <= 1'b0;
            drop_req <= 1'b0;
        end else begin
            btn_q    <= mouse_left;
            armed    <= 1'b1;
            drop_req <= frame_tick ? 1'b0 : req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FOLLOW;
            rect_xpos <= '0;
            rect_ypos <= '0;
            vel       <= '0;
            moving    <= 1'b0;
        end else if (frame_tick) begin
            case (state)
                FOLLOW: begin
                    rect_xpos <= mouse_xpos;
                    rect_ypos <= mouse_y_cl;
                    if (req) begin
                        state  <= FALL;
                        vel    <= '0;
                        moving <= 1'b1;
                    end
                end
                FALL: begin
                    if (fall_sum >= {1'b0, FLOOR}) begin
                        rect_ypos <= FLOOR;
`ifdef RECT_DROP_BOUNCE_EN
                        if (bounce_v < MINB) begin
                            state  <= REST;
                            vel    <= '0;
                            moving <= 1'b0;
                        end else begin
                            state <= RISE;
                            vel   <= bounce_v;
                        end
`else
                        state  <= REST;
                        vel    <= '0;
                        moving <= 1'b0;
`endif
                    end else begin
                        rect_ypos <= fall_sum[11:0];
                        vel       <= (vel_inc > {1'b0, VLIM}) ? VLIM : vel_inc[11:0];
                    end
                end
`ifdef RECT_DROP_BOUNCE_EN
                RISE: begin
                    rect_ypos <= rise_diff[12] ? '0 : rise_diff[11:0];
                    if (vel <= GRAV) begin
                        vel   <= '0;
                        state <= FALL;
                    end else begin
                        vel <= vel - GRAV;
                    end
                end
`endif
                REST: begin
                    if (req) state <= FOLLOW;
                end
                default: begin
                    state  <= FOLLOW;
                    moving <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_drop_ctl.sv
// Self-checking bench for rect_drop_ctl: vector table, drop/bounce/reset sequences, random run vs. reference model.
module tb_rect_drop_ctl;

    localparam int FLOOR = 536;
    localparam int GRAV  = 1;
    localparam int VMAXV = 64;
    localparam int MINB  = 4;
`ifdef RECT_DROP_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic [11:0] rect_xpos;
    logic [11:0] rect_ypos;
    logic        moving;

    rect_drop_ctl #(
        .FLOOR_Y(FLOOR),
        .GRAVITY(GRAV),
        .VMAX(VMAXV),
        .MIN_BOUNCE(MINB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_tick(frame_tick),
        .mouse_left(mouse_left),
        .mouse_xpos(mouse_xpos),
        .mouse_ypos(mouse_ypos),
        .rect_xpos(rect_xpos),
        .rect_ypos(rect_ypos),
        .moving(moving)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: behaviour derived directly from the motion rules, in plain integers.
    typedef enum int {M_FOLLOW, M_FALL, M_RISE, M_REST} mode_t;
    mode_t m_mode;
    int    m_x, m_y, m_vel;
    bit    m_moving, m_prev, m_armed, m_req;

    task automatic model_reset();
        m_mode = M_FOLLOW; m_x = 0; m_y = 0; m_vel = 0;
        m_moving = 0; m_prev = 0; m_armed = 0; m_req = 0;
    endtask

    task automatic model_cycle(input bit tick, input bit left, input int mx, input int my);
        bit rise_ev;
        bit req;
        int nv;
        rise_ev = left && !m_prev && m_armed;
        m_prev  = left;
        m_armed = 1;
        req     = m_req || rise_ev;
        if (!tick) begin
            m_req = req;
            return;
        end
        m_req = 0;
        case (m_mode)
            M_FOLLOW: begin
                m_x = mx;
                m_y = (my > FLOOR) ? FLOOR : my;
                if (req) begin m_mode = M_FALL; m_vel = 0; end
            end
            M_FALL: begin
                if (m_y + m_vel >= FLOOR) begin
                    m_y = FLOOR;
                    nv  = m_vel - m_vel / 4;
                    if (!BOUNCE || nv < MINB) begin m_mode = M_REST; m_vel = 0; end
                    else begin m_mode = M_RISE; m_vel = nv; end
                end else begin
                    m_y   = m_y + m_vel;
                    m_vel = (m_vel + GRAV > VMAXV) ? VMAXV : m_vel + GRAV;
                end
            end
            M_RISE: begin
                m_y   = (m_y - m_vel < 0) ? 0 : m_y - m_vel;
                m_vel = (m_vel - GRAV < 0) ? 0 : m_vel - GRAV;
                if (m_vel == 0) m_mode = M_FALL;
            end
            default: begin
                if (req) m_mode = M_FOLLOW;
            end
        endcase
        m_moving = (m_mode == M_FALL) || (m_mode == M_RISE);
    endtask

    task automatic step(input bit tick, input bit left, input int mx, input int my);
        @(negedge clk);
        frame_tick = tick;
        mouse_left = left;
        mouse_xpos = 12'(mx);
        mouse_ypos = 12'(my);
        @(posedge clk);
        model_cycle(tick, left, mx, my);
        #1;
    endtask

    task automatic check_model(input string name);
        check({name, "_x"}, int'(rect_xpos), m_x);
        check({name, "_y"}, int'(rect_ypos), m_y);
        check({name, "_moving"}, int'(moving), int'(m_moving));
    endtask

    task automatic check_out(input string name, input int ex, input int ey, input int em);
        check({name, "_x"}, int'(rect_xpos), ex);
        check({name, "_y"}, int'(rect_ypos), ey);
        check({name, "_moving"}, int'(moving), em);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit tick;
        bit left;
        int mx, my;
        int ex, ey;
        bit em;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit lft;
        tbl[0]  = '{0, 0, 100, 700, 0, 0, 0};
        tbl[1]  = '{1, 0, 100, 700, 100, 536, 0};
        tbl[2]  = '{0, 0, 300, 20, 100, 536, 0};
        tbl[3]  = '{1, 0, 300, 20, 300, 20, 0};
        tbl[4]  = '{1, 0, 4095, 4095, 4095, 536, 0};
        tbl[5]  = '{1, 0, 0, 536, 0, 536, 0};
        tbl[6]  = '{1, 0, 7, 535, 7, 535, 0};
        tbl[7]  = '{0, 1, 200, 0, 7, 535, 0};
        tbl[8]  = '{0, 0, 200, 0, 7, 535, 0};
        tbl[9]  = '{1, 0, 200, 0, 200, 0, 1};
        tbl[10] = '{1, 0, 999, 999, 200, 0, 1};
        tbl[11] = '{1, 0, 999, 999, 200, 1, 1};
        tbl[12] = '{1, 0, 999, 999, 200, 3, 1};
        tbl[13] = '{0, 0, 999, 999, 200, 3, 1};
        tbl[14] = '{1, 0, 999, 999, 200, 6, 1};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_out("reset", 0, 0, 0);
        #1 rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].tick, tbl[i].left, tbl[i].mx, tbl[i].my);
            check_out($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, int'(tbl[i].em));
        end

        // Fall ticks 5..33 follow y = n(n-1)/2; a press mid-fall is ignored
        for (int n = 5; n <= 33; n++) begin
            if (n == 10) begin
                step(0, 1, 5, 5);
                check_out("press_in_fall_hold", 200, 36, 1);
                step(0, 0, 5, 5);
            end
            step(1, 0, 5, 5);
            check_out($sformatf("fall%0d", n), 200, n * (n - 1) / 2, 1);
        end
        step(1, 0, 5, 5);
        check_out("floor_hit", 200, 536, BOUNCE ? 1 : 0);
        step(1, 0, 5, 5);
        check_out("after_floor", 200, BOUNCE ? 511 : 536, BOUNCE ? 1 : 0);

        for (int i = 0; i < 3000 && m_mode != M_REST; i++) begin
            step(1, 0, 5, 5);
            check_model("bounce");
        end
        check_out("rest", 200, 536, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 9, 9);
            check_out("rest_hold", 200, 536, 0);
        end

        // Press in REST: back to FOLLOW, mouse visible on the tick after
        step(0, 1, 300, 400);
        step(1, 0, 300, 400);
        check_out("rest_exit", 200, 536, 0);
        step(1, 0, 300, 400);
        check_out("follow_again", 300, 400, 0);

        // Press in the same cycle as the tick starts the drop at that tick
        step(1, 1, 50, 100);
        check_out("same_cycle_press", 50, 100, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 50, 100);
        check_out("mid_fall", 50, 110, 1);

        // Async reset mid-fall with the button held
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_out("async_reset", 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 check_out("reset_held", 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        step(1, 1, 77, 88);
        check_out("held_not_edge", 77, 88, 0);
        step(1, 1, 77, 900);
        check_out("held_still_follow", 77, 536, 0);
        step(0, 0, 1, 1);
        step(1, 1, 5, 6);
        check_out("press_after_reset", 5, 6, 1);

        // Randomized run against the reference model
        do_reset();
        lft = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 8 == 0) lft = ~lft;
            step(($urandom % 3) == 0, lft, int'($urandom % 4096),
                 ($urandom % 4 == 0) ? int'($urandom % 4096) : int'($urandom % 600));
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
